// File: rtl/qdiv_arbiter_if.sv
// qdiv_arbiter_if
// Bundles the request, response and divider handshake signals of qdiv_arbiter.
//   req_valid/req_ready        : per-requester valid and one-hot grant
//   req_dividend/req_divisor   : flattened operands, requester i at [i*W +: W]
//   resp_valid/resp_ready      : response handshake
//   resp_id/resp_quotient/resp_divzero : tagged sign-magnitude Q15 result
//   div_dividend/div_divisor/div_start : operands and start pulse to the divider
//   div_quotient/div_complete  : divider result and idle/result-valid flag
// Modport slave is the arbiter's view; master is the environment's view.
interface qdiv_arbiter_if #(
    parameter int NREQ = 4,
    parameter int W    = 32,
    parameter int IDW  = $clog2(NREQ)
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_dividend;
    logic [NREQ*W-1:0] req_divisor;
    logic              resp_valid;
    logic              resp_ready;
    logic [IDW-1:0]    resp_id;
    logic [W-1:0]      resp_quotient;
    logic              resp_divzero;
    logic [W-1:0]      div_dividend;
    logic [W-1:0]      div_divisor;
    logic              div_start;
    logic [W-1:0]      div_quotient;
    logic              div_complete;

    modport slave (
        input  req_valid, req_dividend, req_divisor, resp_ready, div_quotient, div_complete,
        output req_ready, resp_valid, resp_id, resp_quotient, resp_divzero,
               div_dividend, div_divisor, div_start
    );

    modport master (
        output req_valid, req_dividend, req_divisor, resp_ready, div_quotient, div_complete,
        input  req_ready, resp_valid, resp_id, resp_quotient, resp_divzero,
               div_dividend, div_divisor, div_start
    );
endinterface

// File: rtl/qdiv_arbiter.sv
// qdiv_arbiter
// Round-robin arbiter and sequencer sharing one multi-cycle sign-magnitude
// fixed-point divider among NREQ requesters. One request is accepted at a time,
// its operands are latched and sent to the divider, and the quotient is returned
// tagged with the requester index.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : qdiv_arbiter_if.slave (request, response and divider channels)
// Optional build macro QDIV_ARB_DIVZERO_EN: a zero-magnitude divisor bypasses
// the divider and returns a saturated quotient with resp_divzero=1.
module qdiv_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 32,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic           clk,
    input  logic           rst,
    qdiv_arbiter_if.slave  bus
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_LOW, WAIT_HIGH, RESP} state_t;

    state_t          state;
    logic [IDW-1:0]  last_grant;
    logic [IDW-1:0]  win_idx;
    logic            win_found;
    logic [NREQ-1:0] grant;
    logic [W-1:0]    sel_dividend;
    logic [W-1:0]    sel_divisor;

    logic            resp_valid_r;
    logic [IDW-1:0]  resp_id_r;
    logic [W-1:0]    resp_quotient_r;
    logic            div_start_r;
    logic [W-1:0]    div_dividend_r;
    logic [W-1:0]    div_divisor_r;

`ifdef QDIV_ARB_DIVZERO_EN
    logic            resp_divzero_r;

    // Saturated magnitude with the quotient's sign.
    function automatic logic [W-1:0] divzero_quotient(input logic dvd_sign, input logic dvs_sign);
        return {dvd_sign ^ dvs_sign, {(W-1){1'b1}}};
    endfunction
`endif

    // Rotating-priority search starting just after the last accepted requester.
    always_comb begin
        logic [IDW:0] pos;
        win_found = 1'b0;
        win_idx   = '0;
        pos       = '0;
        for (int i = 1; i <= NREQ; i++) begin
            pos = {1'b0, last_grant} + (IDW+1)'(i);
            if (pos >= (IDW+1)'(NREQ)) pos = pos - (IDW+1)'(NREQ);
            if (!win_found && bus.req_valid[pos[IDW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = pos[IDW-1:0];
            end
        end
    end

    // Grant only when the divider is idle so a start never hits a busy divider;
    // rst masks the grant so a handshake coinciding with reset is not seen.
    always_comb begin
        grant = '0;
        if (state == IDLE && bus.div_complete && win_found && !rst) grant[win_idx] = 1'b1;
    end

    always_comb begin
        sel_dividend = '0;
        sel_divisor  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_idx == IDW'(i)) begin
                sel_dividend = bus.req_dividend[i*W +: W];
                sel_divisor  = bus.req_divisor[i*W +: W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            last_grant      <= IDW'(NREQ-1);
            resp_valid_r    <= 1'b0;
            resp_id_r       <= '0;
            resp_quotient_r <= '0;
            div_start_r     <= 1'b0;
            div_dividend_r  <= '0;
            div_divisor_r   <= '0;
`ifdef QDIV_ARB_DIVZERO_EN
            resp_divzero_r  <= 1'b0;
`endif
        end else begin
            div_start_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (|grant) begin
                        last_grant     <= win_idx;
                        resp_id_r      <= win_idx;
                        div_dividend_r <= sel_dividend;
                        div_divisor_r  <= sel_divisor;
`ifdef QDIV_ARB_DIVZERO_EN
                        if (sel_divisor[W-2:0] == '0) begin
                            state           <= RESP;
                            resp_valid_r    <= 1'b1;
                            resp_quotient_r <= divzero_quotient(sel_dividend[W-1], sel_divisor[W-1]);
                            resp_divzero_r  <= 1'b1;
                        end else begin
                            state          <= ISSUE;
                            div_start_r    <= 1'b1;
                            resp_divzero_r <= 1'b0;
                        end
`else
                        state       <= ISSUE;
                        div_start_r <= 1'b1;
`endif
                    end
                end
                // Start pulse is on the wire this cycle; the divider drops complete next.
                ISSUE: state <= WAIT_LOW;
                WAIT_LOW: begin
                    if (!bus.div_complete) state <= WAIT_HIGH;
                end
                WAIT_HIGH: begin
                    if (bus.div_complete) begin
                        resp_quotient_r <= bus.div_quotient;
                        resp_valid_r    <= 1'b1;
                        state           <= RESP;
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        resp_valid_r <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready     = grant;
    assign bus.resp_valid    = resp_valid_r;
    assign bus.resp_id       = resp_id_r;
    assign bus.resp_quotient = resp_quotient_r;
    assign bus.div_start     = div_start_r;
    assign bus.div_dividend  = div_dividend_r;
    assign bus.div_divisor   = div_divisor_r;
`ifdef QDIV_ARB_DIVZERO_EN
    assign bus.resp_divzero  = resp_divzero_r;
`else
    assign bus.resp_divzero  = 1'b0;
`endif

endmodule

// File: tb/tb_qdiv_arbiter.sv
// tb_qdiv_arbiter
// Bench for qdiv_arbiter with a behavioural 46-cycle divider, a rotating-priority
// reference model and a response scoreboard. Honours QDIV_ARB_DIVZERO_EN.
module tb_qdiv_arbiter;
    localparam int NREQ = 4;
    localparam int W    = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    qdiv_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();
    qdiv_arbiter #(.NREQ(NREQ), .W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        int          id;
        logic [31:0] q;
        logic        dz;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   m_busy = 1'b0;
    int   m_last = NREQ-1;
    int   start_due = -1;
    bit   done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Sign-magnitude Q15 divide from first principles; zero divisor saturates.
    function automatic logic [31:0] ref_q(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] num;
        logic [63:0] mag;
        if (b[30:0] == 31'd0) return {a[31] ^ b[31], 31'h7FFFFFFF};
        num = {33'd0, a[30:0]} << 15;
        mag = num / {33'd0, b[30:0]};
        return {a[31] ^ b[31], mag[30:0]};
    endfunction

    function automatic bit ref_dz(input logic [31:0] b);
`ifdef QDIV_ARB_DIVZERO_EN
        return b[30:0] == 31'd0;
`else
        return 1'b0;
`endif
    endfunction

    // Behavioural divider: no reset, complete low for 46 cycles after a start.
    initial begin
        int cnt;
        logic [31:0] da, db;
        cnt = 0; da = '0; db = '0;
        bus.div_complete = 1'b1;
        bus.div_quotient = '0;
        forever begin
            @(posedge clk);
            if (bus.div_complete && bus.div_start) begin
                da = bus.div_dividend;
                db = bus.div_divisor;
                cnt = 45;
                bus.div_complete <= 1'b0;
                bus.div_quotient <= $urandom;
            end else if (!bus.div_complete) begin
                if (cnt == 0) begin
                    bus.div_complete <= 1'b1;
                    bus.div_quotient <= ref_q(da, db);
                end else cnt--;
            end
        end
    end

    // Reference model: predicts grants and start pulses, pushes expected responses.
    always @(negedge clk) begin
        logic [NREQ-1:0] exp_g;
        int w, j;
        logic [31:0] a, b;
        exp_t e;
        if (rst) begin
            m_busy = 1'b0;
            m_last = NREQ-1;
            start_due = -1;
            sb.delete();
            check("req_ready_in_reset", bus.req_ready, 0);
        end else begin
            exp_g = '0;
            w = -1;
            if (!m_busy && bus.div_complete) begin
                for (int k = 1; k <= NREQ; k++) begin
                    j = (m_last + k) % NREQ;
                    if (w < 0 && bus.req_valid[j]) w = j;
                end
            end
            if (w >= 0) exp_g[w] = 1'b1;
            check("req_ready", bus.req_ready, exp_g);
            check("div_start", bus.div_start, cyc == start_due);
            if (w >= 0) begin
                a = bus.req_dividend[w*W +: W];
                b = bus.req_divisor[w*W +: W];
                e.id  = w;
                e.q   = ref_q(a, b);
                e.dz  = ref_dz(b);
                e.acc = cyc;
                e.lat = e.dz ? 1 : 49;
                sb.push_back(e);
                m_busy = 1'b1;
                m_last = w;
                if (!e.dz) start_due = cyc + 1;
            end
        end
    end

    // Monitor: compares every presented response against the scoreboard head.
    always @(negedge clk) begin
        static bit prev_valid = 1'b0;
        static bit prev_ready = 1'b0;
        exp_t e;
        if (rst) begin
            prev_valid = 1'b0;
            prev_ready = 1'b0;
        end else begin
            if (bus.resp_valid) begin
                if (sb.size() == 0) check("resp_unexpected", 1, 0);
                else begin
                    e = sb[0];
                    check("resp_id", bus.resp_id, e.id);
                    check("resp_quotient", bus.resp_quotient, e.q);
                    check("resp_divzero", bus.resp_divzero, e.dz);
                    if (!prev_valid) check("resp_latency", cyc - e.acc, e.lat);
                    if (bus.resp_ready) begin
                        void'(sb.pop_front());
                        m_busy <= 1'b0;
                    end
                end
            end else if (prev_valid && !prev_ready) begin
                check("resp_dropped", 0, 1);
            end
            prev_valid = bus.resp_valid;
            prev_ready = bus.resp_ready;
        end
    end

    task automatic issue(input int id, input logic [31:0] a, input logic [31:0] b, output int acc);
        bit got;
        got = 1'b0;
        acc = -1;
        bus.req_dividend[id*W +: W] = a;
        bus.req_divisor[id*W +: W]  = b;
        bus.req_valid[id] = 1'b1;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (bus.req_ready[id]) begin got = 1'b1; acc = cyc; break; end
        end
        check("grant_timeout", got, 1);
        @(posedge clk); #1;
        bus.req_valid[id] = 1'b0;
    endtask

    task automatic wait_resp(output int rc);
        bit got;
        got = 1'b0;
        rc = -1;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (bus.resp_valid) begin got = 1'b1; rc = cyc; break; end
        end
        check("resp_timeout", got, 1);
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (sb.size() == 0 && !bus.resp_valid && bus.div_complete) begin ok = 1'b1; break; end
        end
        check("drain_timeout", ok, 1);
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs();
        check("rst_resp_valid", bus.resp_valid, 0);
        check("rst_resp_id", bus.resp_id, 0);
        check("rst_resp_quotient", bus.resp_quotient, 0);
        check("rst_resp_divzero", bus.resp_divzero, 0);
        check("rst_div_start", bus.div_start, 0);
        check("rst_div_dividend", bus.div_dividend, 0);
        check("rst_div_divisor", bus.div_divisor, 0);
        check("rst_req_ready", bus.req_ready, 0);
    endtask

    initial begin
        int acc, rc, gid;
        bit got;
        bus.req_valid = '0;
        bus.req_dividend = '0;
        bus.req_divisor = '0;
        bus.resp_ready = 1'b1;

        // Reset with every requester already valid: fairness from reset.
        for (int i = 0; i < NREQ; i++) begin
            bus.req_dividend[i*W +: W] = 32'h0001_0000 * (i + 1);
            bus.req_divisor[i*W +: W]  = 32'h0000_8000;
        end
        bus.req_valid = '1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        rst = 1'b0;
        for (int g = 0; g < 5; g++) begin
            got = 1'b0;
            gid = -1;
            for (int n = 0; n < 200 && !got; n++) begin
                @(negedge clk);
                for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) begin got = 1'b1; gid = i; end
            end
            check("fair_order", gid, g % NREQ);
            @(posedge clk); #1;
        end
        bus.req_valid = '0;
        drain();

        // Single request: 3.0 / 2.0.
        issue(0, 32'h0001_8000, 32'h0001_0000, acc);
        wait_resp(rc);
        check("single_quotient", bus.resp_quotient, 32'h0000_C000);
        check("single_id", bus.resp_id, 0);
        check("single_latency", rc - acc, 49);
        drain();

        // Negative dividend: -3.0 / 2.0.
        issue(2, 32'h8001_8000, 32'h0001_0000, acc);
        wait_resp(rc);
        check("sign_quotient", bus.resp_quotient, 32'h8000_C000);
        check("sign_id", bus.resp_id, 2);
        drain();

        // Backpressure with another requester waiting.
        bus.resp_ready = 1'b0;
        issue(1, 32'h0003_0000, 32'h0000_4000, acc);
        bus.req_dividend[3*W +: W] = 32'h0000_4000;
        bus.req_divisor[3*W +: W]  = 32'h0002_0000;
        bus.req_valid[3] = 1'b1;
        wait_resp(rc);
        repeat (20) @(negedge clk);
        @(posedge clk); #1;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        check("bp_handshake_valid", bus.resp_valid, 1);
        @(negedge clk);
        check("bp_next_grant", bus.req_ready, 4'b1000);
        @(posedge clk); #1;
        bus.req_valid[3] = 1'b0;
        drain();

        // Zero-magnitude divisor.
        issue(3, 32'h0001_0000, 32'h8000_0000, acc);
        wait_resp(rc);
        check("dz_quotient", bus.resp_quotient, 32'hFFFF_FFFF);
`ifdef QDIV_ARB_DIVZERO_EN
        check("dz_flag", bus.resp_divzero, 1);
        check("dz_latency", rc - acc, 1);
`else
        check("dz_flag", bus.resp_divzero, 0);
        check("dz_latency", rc - acc, 49);
`endif
        drain();

        // Reset in the middle of a divide.
        issue(0, 32'h0005_0000, 32'h0001_8000, acc);
        while (cyc < acc + 10) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_reset_outputs();
        bus.req_valid[1] = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clk);
            if (bus.req_ready[1]) begin got = 1'b1; check("midrst_grant_cycle", cyc, acc + 48); end
        end
        check("midrst_grant_seen", got, 1);
        @(posedge clk); #1;
        bus.req_valid[1] = 1'b0;
        drain();

        // Randomized traffic with random backpressure and dropped requests.
        for (int t = 0; t < 3000; t++) begin
            logic [31:0] b;
            bus.req_valid = NREQ'($urandom_range(0, 15));
            for (int i = 0; i < NREQ; i++) begin
                b = $urandom;
                if ($urandom_range(0, 7) == 0) b = b & 32'h8000_0000;
                bus.req_dividend[i*W +: W] = $urandom;
                bus.req_divisor[i*W +: W]  = b;
            end
            bus.resp_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        bus.req_valid = '0;
        bus.resp_ready = 1'b1;
        drain();

        done = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        repeat (20000) @(posedge clk);
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL global_timeout: got cycle %0d required completion", cyc);
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
            $finish;
        end
    end
endmodule

// File: doc/qdiv_arbiter.md
# qdiv_arbiter

Round-robin arbiter and sequencer that shares one multi-cycle sign-magnitude fixed-point divider (`qdiv`, N=32, Q=15) among NREQ requesters. It accepts one request at a time over a valid/ready handshake and latches the operands. It drives the divider's start/complete handshake, then returns the quotient tagged with the requester index on a valid/ready response channel. It sits between the datapath clients and the single `qdiv` instance.

## Interface
- NREQ, 4, number of requesters (2..8)
- W, 32, operand/quotient width; must equal the divider's N
- IDW, $clog2(NREQ), requester-index width (derived)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  one-hot grant; request i accepted when req_valid[i] && req_ready[i]
- req_dividend  in  NREQ*W  flattened; requester i at [i*W +: W]
- req_divisor  in  NREQ*W  flattened; requester i at [i*W +: W]
- resp_valid  out  1  response valid
- resp_ready  in  1  response consumer ready
- resp_id  out  IDW  index of the requester being answered
- resp_quotient  out  W  sign-magnitude Q15 quotient
- resp_divzero  out  1  divisor magnitude was zero (see Configuration)
- div_dividend  out  W  to divider, held stable from ISSUE until RESP
- div_divisor  out  W  to divider, held stable from ISSUE until RESP
- div_start  out  1  to divider start, one-cycle pulse
- div_quotient  in  W  from divider
- div_complete  in  1  from divider; high = idle / result valid

## Operation
- States: IDLE, ISSUE, WAIT_LOW, WAIT_HIGH, RESP.
- IDLE: if div_complete=1 and any req_valid, assert req_ready for the winner only. On the same edge, latch operands into registers, latch the index, and go to ISSUE. If div_complete=0, grant nothing.
- Round-robin: search starts at (last_grant+1) mod NREQ; after reset last_grant=NREQ-1, so requester 0 has first priority. last_grant updates only on acceptance.
- ISSUE: div_start=1 for exactly one cycle, then WAIT_LOW.
- WAIT_LOW: stay until div_complete=0, then WAIT_HIGH.
- WAIT_HIGH: stay until div_complete=1. On that edge, capture div_quotient into resp_quotient and go to RESP.
- RESP: resp_valid=1; resp_id, resp_quotient and resp_divzero hold stable. On resp_valid && resp_ready, go to IDLE. No new request is accepted while in RESP.
- The arbiter does not interpret arithmetic. The quotient passes through unchanged: bit W-1 is the sign, bits W-2:0 are the Q15 magnitude.

## Timing
- Reset values: req_ready=0, resp_valid=0, resp_id=0, resp_quotient=0, resp_divzero=0, div_start=0, div_dividend=0, div_divisor=0, state=IDLE.
- The divider has no reset. If rst occurs mid-operation, the in-flight result is dropped. After reset the arbiter grants nothing until it samples div_complete=1, so it never pulses div_start into a busy divider.
- Latency with the 46-cycle divider busy time:
  - acceptance in cycle A
  - div_start in A+1
  - div_complete low A+2..A+47
  - resp_valid first high in A+49
- Throughput with resp_ready held high: one operation per 50 cycles.
- req_ready is combinational from state, div_complete, req_valid and last_grant. A requester may drop req_valid without being granted.
- A simultaneous reset and handshake: reset wins and nothing is accepted.

## Configuration
- QDIV_ARB_DIVZERO_EN defined: at acceptance, if divisor[W-2:0]==0, the divider is bypassed and the next state is RESP.
  - resp_valid is high in A+1.
  - resp_quotient = {dividend[W-1]^divisor[W-1], {W-1{1'b1}}}.
  - resp_divzero=1.
  - div_start is not pulsed.
- Undefined: zero divisors are sent through the divider like any other operand. resp_divzero is tied to 0.

## Test plan
- Single request: requester 0, dividend 0x00018000 (3.0), divisor 0x00010000 (2.0) -> resp_quotient 0x0000C000, resp_id 0, resp_valid in A+49.
- Sign: requester 2, dividend 0x80018000 (-3.0), divisor 0x00010000 -> resp_quotient 0x8000C000, resp_id 2.
- Fairness: all four requesters valid continuously from reset -> grant order 0,1,2,3,0. Exactly one div_start per grant, never while div_complete=0.
- Backpressure: resp_ready low for 20 cycles after resp_valid -> resp fields stable, no req_ready asserted; resp_ready high -> IDLE next cycle, next grant the cycle after.
- Reset mid-op: assert rst in A+10 -> all outputs at reset values. No grant before div_complete returns high (A+48); a pending request is granted in that cycle.
- Divide-by-zero: divisor 0x80000000, dividend 0x00010000 -> with macro: resp_quotient 0xFFFFFFFF, resp_divzero=1 in A+1, no div_start. Without macro: divider path taken, resp_divzero=0.
